// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, runs a fixed-latency busy period
// per MULT/DIV operation and raises a D-stage stall while it is occupied.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        md_stall
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  md_op_t      op_in, op_q;
  logic [31:0] a_q, b_q;
  logic        is_arith, commit;
  logic [31:0] hi_res, lo_res;

  logic [63:0] prod;
  logic        signed_div;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  assign op_in    = md_op_t'(md_op_E);
  assign is_arith = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                    (op_in == OP_DIV)  || (op_in == OP_DIVU);
  assign busy     = (state == RUN);
  assign md_stall = md_use_D & (busy | is_arith);

  always_comb begin
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (is_arith) begin
          state_next = RUN;
          count_next = ((op_in == OP_MULT) || (op_in == OP_MULTU)) ? MULT_LAT : DIV_LAT;
        end
      end
      RUN: begin
        if (count == 4'd1) begin
          state_next = IDLE;
          count_next = '0;
          commit     = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One unsigned divider serves both DIV and DIVU; DIV works on magnitudes
  // and restores signs afterwards, which also yields the INT_MIN/-1 result.
  always_comb begin
    signed_div = (op_q == OP_DIV);
    a_mag      = (signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
    b_mag      = (signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;
    q_mag      = (b_mag != '0) ? (a_mag / b_mag) : '0;
    r_mag      = (b_mag != '0) ? (a_mag % b_mag) : '0;
    prod       = '0;
    hi_res     = HI;
    lo_res     = LO;
    case (op_q)
      OP_MULT: begin
        prod   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        hi_res = prod[63:32];
        lo_res = prod[31:0];
      end
      OP_MULTU: begin
        prod   = {32'd0, a_q} * {32'd0, b_q};
        hi_res = prod[63:32];
        lo_res = prod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_q == '0) begin
          hi_res = a_q;
          lo_res = '1;
        end else begin
          lo_res = (signed_div && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
          hi_res = (signed_div && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == IDLE && is_arith) begin
        op_q <= op_in;
        a_q  <= A_E;
        b_q  <= B_E;
      end
      if (commit) begin
        HI <= hi_res;
        LO <= lo_res;
      end else if (state == IDLE) begin
        if (op_in == OP_MTHI) HI <= A_E;
        if (op_in == OP_MTLO) LO <= A_E;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: cycle-by-cycle comparison against a
// transaction-level model, plus literal expectations for key scenarios.
module tb_md_sequencer;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op_E;
  logic [31:0] A_E, B_E;
  logic        md_use_D;
  logic        busy;
  logic [31:0] HI, LO;
  logic        md_stall;

  int passed = 0;
  int total  = 0;

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op_E  (md_op_E),
    .A_E      (A_E),
    .B_E      (B_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .md_stall (md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: a pending result and the cycle index whose
  // closing edge commits it.
  logic        pend = 1'b0;
  int          cyc = 0;
  int          commit_at = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  function automatic void compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint          ps;
    longint unsigned pu;
    int              sa, sb;
    hi = '0;
    lo = '0;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin
        ps = longint'(sa) * longint'(sb);
        hi = ps[63:32];
        lo = ps[31:0];
      end
      3'd2: begin
        pu = longint'(a) * longint'(b);
        hi = pu[63:32];
        lo = pu[31:0];
      end
      3'd3: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin hi = 32'd0; lo = 32'h80000000; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      3'd4: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend = 1'b0;
      m_hi = '0;
      m_lo = '0;
    end else begin
      if (pend) begin
        if (cyc == commit_at) begin
          m_hi = p_hi;
          m_lo = p_lo;
          pend = 1'b0;
        end
      end else if (md_op_E >= 3'd1 && md_op_E <= 3'd4) begin
        compute(md_op_E, A_E, B_E, p_hi, p_lo);
        pend = 1'b1;
        commit_at = cyc + ((md_op_E <= 3'd2) ? MC : DC);
      end else if (md_op_E == 3'd5) begin
        m_hi = A_E;
      end else if (md_op_E == 3'd6) begin
        m_lo = A_E;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, pend});
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    check("stall", {31'd0, md_stall},
          {31'd0, md_use_D & (pend | (md_op_E >= 3'd1 && md_op_E <= 3'd4))});
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
    md_op_E  = op;
    A_E      = a;
    B_E      = b;
    md_use_D = use_d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int i = 0; i < n; i++) drive(3'd0, 32'd0, 32'd0, use_d);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b, 1'b0);
    idle((op <= 3'd2) ? MC : DC, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    md_op_E  = 3'd0;
    A_E      = '0;
    B_E      = '0;
    md_use_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;

    // MULT -2 * 3 accepted in the first cycle after reset
    drive(3'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    for (int i = 0; i < MC; i++) begin
      check("mult_busy", {31'd0, busy}, 32'd1);
      check("mult_stall", {31'd0, md_stall}, 32'd1);
      check("mult_hi_hold", HI, 32'd0);
      drive(3'd0, 32'd0, 32'd0, 1'b1);
    end
    check("mult_done_busy", {31'd0, busy}, 32'd0);
    check("mult_done_stall", {31'd0, md_stall}, 32'd0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFA);

    drive(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("nouse_stall", {31'd0, md_stall}, 32'd0);
    idle(MC, 1'b0);
    check("multu_hi", HI, 32'hFFFFFFFE);
    check("multu_lo", LO, 32'h00000001);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    run_op(3'd4, 32'd7, 32'd0);
    check("divu0_lo", LO, 32'hFFFFFFFF);
    check("divu0_hi", HI, 32'd7);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("divovf_lo", LO, 32'h80000000);
    check("divovf_hi", HI, 32'd0);

    run_op(3'd3, 32'd7, 32'hFFFFFFFE);
    check("div_neg_lo", LO, 32'hFFFFFFFD);
    check("div_neg_hi", HI, 32'd1);

    run_op(3'd3, 32'h12345678, 32'd0);
    run_op(3'd4, 32'hFFFFFFF0, 32'd7);
    run_op(3'd1, 32'h7FFFFFFF, 32'h80000000);
    run_op(3'd2, 32'hDEADBEEF, 32'h01234567);

    // Ops issued while busy must be dropped
    drive(3'd1, 32'd2, 32'd3, 1'b1);
    drive(3'd5, 32'h12345678, 32'd0, 1'b1);
    drive(3'd6, 32'h0BADF00D, 32'd0, 1'b1);
    drive(3'd3, 32'd9, 32'd4, 1'b1);
    idle(MC - 3, 1'b1);
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd6);

    drive(3'd5, 32'h12345678, 32'd0, 1'b1);
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    drive(3'd6, 32'hCAFEF00D, 32'd0, 1'b0);
    check("mtlo_lo", LO, 32'hCAFEF00D);
    drive(3'd7, 32'h55555555, 32'd1, 1'b1);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", HI, 32'h12345678);
    idle(1, 1'b0);

    // Reset in the fourth busy cycle of a DIV aborts it
    drive(3'd5, 32'h0000AAAA, 32'd0, 1'b0);
    drive(3'd3, 32'd100, 32'd7, 1'b0);
    idle(3, 1'b0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset    = 1'b1;
    md_op_E  = 3'd3;
    md_use_D = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    check("abort_stall", {31'd0, md_stall}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(DC + 2, 1'b0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);
    check("abort_late_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning the busy duration in cycles for MULT/MULTU (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning the busy duration in cycles for DIV/DIVU (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port md_op_E, input, 3, the E-stage operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved and treated as NONE.
REQ-006 SHALL have port A_E, input, 32, the rs operand, already forwarded.
REQ-007 SHALL have port B_E, input, 32, the rt operand, already forwarded.
REQ-008 SHALL have port md_use_D, input, 1, meaning the D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-009 SHALL have port busy, output, 1, meaning an operation is in flight.
REQ-010 SHALL have port HI, output, 32, the architectural HI register.
REQ-011 SHALL have port LO, output, 32, the architectural LO register.
REQ-012 SHALL have port md_stall, output, 1, a D-stage stall request to be ORed into the pipeline stall.

Function
REQ-013 A start SHALL occur in cycle t when md_op_E is in 1..4 and busy=0.
- Operands A_E/B_E and the op SHALL be latched at the end of cycle t.
- A down-counter SHALL be loaded with MULT_CYCLES or DIV_CYCLES.
REQ-014 busy SHALL be 1 from cycle t+1 through cycle t+N (N = selected latency), and 0 in cycle t+N+1.
REQ-015 HI/LO SHALL update at the rising edge ending cycle t+N, so new values are visible from cycle t+N+1; they SHALL hold their old values while busy.
REQ-016 Result arithmetic:
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-017 Divide boundary cases:
- Divide by zero (DIV or DIVU): LO = 32'hFFFFFFFF, HI = dividend.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
REQ-018 MTHI/MTLO with busy=0 SHALL write A_E into HI or LO at the end of that cycle, with no busy period.
REQ-019 Any md_op_E other than NONE while busy=1 SHALL be ignored, with no state change.
REQ-020 The internal FSM SHALL have states IDLE and RUN:
- IDLE->RUN on start.
- RUN->RUN while counter>1, decrementing each cycle.
- RUN->IDLE when counter==1, performing the commit in the same edge.
REQ-021 md_stall SHALL be combinational: md_stall = md_use_D & (busy | (md_op_E in 1..4)).
REQ-022 No path SHALL exist from md_stall back into this block's state.

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE, counter=0, busy=0, HI=0, LO=0, and latched operands=0; md_stall then equals md_use_D & (md_op_E in 1..4).
REQ-024 Reset asserted mid-operation SHALL abort the operation with no HI/LO commit.
REQ-025 The first start SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-026 MULT with A=32'hFFFFFFFE (-2) and B=3 at cycle t -> busy=1 for cycles t+1..t+5; HI=32'hFFFFFFFF and LO=32'hFFFFFFFA visible at t+6.
REQ-027 MULTU with A=B=32'hFFFFFFFF -> after 5 busy cycles, HI=32'hFFFFFFFE and LO=32'h00000001.
REQ-028 DIV with A=-7 and B=2 -> busy for 10 cycles; then LO=32'hFFFFFFFD and HI=32'hFFFFFFFF. DIVU with A=7 and B=0 -> LO=32'hFFFFFFFF, HI=7.
REQ-029 md_use_D=1 during each busy cycle and during the start cycle -> md_stall=1. With md_use_D=0 -> md_stall=0. At t+N+1 -> md_stall=0.
REQ-030 Reset abort and ignored ops:
- Start DIV, then assert reset at t+4 -> HI=LO=0 and busy=0 immediately; no later commit.
- MTHI with A=32'h12345678 issued while busy -> ignored, HI unchanged.
- MTHI with A=32'h12345678 issued while idle -> HI=32'h12345678 next cycle.
